mult_sched_m: RTL and testbench

Sequencer that runs a full 5x5 signed 8-bit matrix product C = A x B on one shared 2x2 block multiplier.
- Each pass issues one row-pair of A and one column-pair of B, then scatters the four returned elements into C.
- Sits between the coprocessor command/register interface and the block multiplier.
- Handles operand latching, tiling, zero-padding, result assembly, sticky overflow and a start/done handshake.

---
 rtl/mult_sched_m.sv | 193 +++++++++++++++++++
 tb/tb_mult_sched_m.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched_m.sv
// Sequencer for a 5x5 signed 8-bit matrix product on one shared 2x2 block multiplier.
// Latches and zero-pads operands, walks the 2x2 tiles and assembles C with a sticky overflow.
module mult_sched_m #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         size,
    input  logic [N*N*W-1:0]   mat_a,
    input  logic [N*N*W-1:0]   mat_b,
    output logic [2*N*W-1:0]   mult_lin,
    output logic [2*N*W-1:0]   mult_col,
    output logic               mult_rst,
    input  logic [4*W-1:0]     mult_res,
    input  logic               mult_ovf,
    output logic               busy,
    output logic               done,
    output logic [N*N*W-1:0]   result,
    output logic               ovf
);

    localparam int MW = N * N * W;
    localparam int VW = N * W;
    localparam logic [2:0] NMAX = 3'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   a_q   [N][N];
    logic [W-1:0]   b_q   [N][N];
    logic [W-1:0]   a_in  [N][N];
    logic [W-1:0]   b_in  [N][N];
    logic [W-1:0]   a_src [N][N];
    logic [W-1:0]   b_src [N][N];
    logic [W-1:0]   res_q [N][N];
    logic [2:0]     size_in;
    logic [2:0]     size_q;
    logic [1:0]     ti, tj;
    logic [1:0]     nti, ntj;
    logic [1:0]     t1_m1;
    logic           last_tile;
    logic [2*VW-1:0] lin_next;
    logic [2*VW-1:0] col_next;

    // Masked operands; during LOAD the tile vectors are built straight from the inputs
    // because the operand registers only become valid on the same edge.
    always_comb begin
        size_in = (size == 3'd0 || size > NMAX) ? NMAX : size;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                a_in[r][c]  = (r < int'(size_in) && c < int'(size_in)) ? mat_a[MW-1-W*(N*r+c) -: W] : '0;
                b_in[r][c]  = (r < int'(size_in) && c < int'(size_in)) ? mat_b[MW-1-W*(N*r+c) -: W] : '0;
                a_src[r][c] = (state == S_LOAD) ? a_in[r][c] : a_q[r][c];
                b_src[r][c] = (state == S_LOAD) ? b_in[r][c] : b_q[r][c];
            end
        end
    end

    // NOTE: every variable written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        t1_m1     = 2'((size_q - 3'd1) >> 1);
        nti       = ti;
        ntj       = tj;
        last_tile = 1'b0;
        if (state == S_LOAD) begin
            nti = 2'd0;
            ntj = 2'd0;
        end else if (tj < t1_m1) begin
            ntj = tj + 2'd1;
        end else if (ti < t1_m1) begin
            ntj = 2'd0;
            nti = ti + 2'd1;
        end else begin
            last_tile = 1'b1;
        end

        // Row/column index N never matches a stored row, so it stays at the zero default.
        lin_next = '0;
        col_next = '0;
        for (int r = 0; r < N; r++) begin
            if ((r / 2) == int'(nti)) begin
                for (int k = 0; k < N; k++)
                    lin_next[2*VW-1-VW*(r%2)-W*k -: W] = a_src[r][k];
            end
        end
        for (int c = 0; c < N; c++) begin
            if ((c / 2) == int'(ntj)) begin
                for (int k = 0; k < N; k++)
                    col_next[2*VW-1-VW*(c%2)-W*k -: W] = b_src[k][c];
            end
        end
    end

    always_comb begin
        result = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                result[MW-1-W*(N*r+c) -: W] = res_q[r][c];
    end

    // NOTE: operand storage has no reset; it is always rewritten in LOAD before anything reads it.
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= a_in[r][c];
                    b_q[r][c] <= b_in[r][c];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            mult_rst <= 1'b1;
            mult_lin <= '0;
            mult_col <= '0;
            ti       <= 2'd0;
            tj       <= 2'd0;
            size_q   <= NMAX;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    res_q[r][c] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    size_q   <= size_in;
                    ovf      <= 1'b0;
                    ti       <= 2'd0;
                    tj       <= 2'd0;
                    mult_lin <= lin_next;
                    mult_col <= col_next;
                    mult_rst <= 1'b0;
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++)
                            res_q[r][c] <= '0;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    ovf <= ovf | mult_ovf;
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if ((r / 2) == int'(ti) && (c / 2) == int'(tj) &&
                                r < int'(size_q) && c < int'(size_q))
                                res_q[r][c] <= mult_res[4*W-1-W*(2*(r%2)+(c%2)) -: W];
                        end
                    end
                    if (last_tile) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mult_rst <= 1'b1;
                    end else begin
                        ti       <= nti;
                        tj       <= ntj;
                        mult_lin <= lin_next;
                        mult_col <= col_next;
                        state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched_m.sv
// Self-checking bench for mult_sched_m: behavioural 2x2 block multiplier plus a
// scoreboard of reference matrix products popped on each done pulse.
module tb_mult_sched_m;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   size;
    logic [199:0] mat_a, mat_b;
    logic [79:0]  mult_lin, mult_col;
    logic         mult_rst;
    logic [31:0]  mult_res;
    logic         mult_ovf;
    logic         busy, done;
    logic [199:0] result;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [199:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    mult_sched_m dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .size     (size),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .mult_lin (mult_lin),
        .mult_col (mult_col),
        .mult_rst (mult_rst),
        .mult_res (mult_res),
        .mult_ovf (mult_ovf),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Combinational 2x2 block multiplier: 8-bit wrapped results, flag on any out-of-range dot product.
    always_comb begin
        int sum;
        mult_res = '0;
        mult_ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                sum = 0;
                for (int k = 0; k < 5; k++)
                    sum += int'($signed(mult_lin[79-40*i-8*k -: 8])) * int'($signed(mult_col[79-40*j-8*k -: 8]));
                mult_res[31-8*(2*i+j) -: 8] = sum[7:0];
                if (sum > 127 || sum < -128) mult_ovf = 1'b1;
            end
        end
        if (mult_rst) begin
            mult_res = '0;
            mult_ovf = 1'b0;
        end
    end

    // kind 0: identity, 1: every element v, 2: 1..25 row-major
    function automatic logic [199:0] mk(input int kind, input int v);
        logic [199:0] m;
        int e;
        m = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                e = (kind == 0) ? int'(r == c) : (kind == 1) ? v : 5 * r + c + 1;
                m[199-8*(5*r+c) -: 8] = 8'(e);
            end
        end
        return m;
    endfunction

    function automatic exp_t ref_model(input logic [199:0] a, input logic [199:0] b, input int s);
        exp_t e;
        int sum;
        e.res = '0;
        e.ovf = 1'b0;
        for (int r = 0; r < s; r++) begin
            for (int c = 0; c < s; c++) begin
                sum = 0;
                for (int k = 0; k < s; k++)
                    sum += int'($signed(a[199-8*(5*r+k) -: 8])) * int'($signed(b[199-8*(5*k+c) -: 8]));
                e.res[199-8*(5*r+c) -: 8] = sum[7:0];
                if (sum > 127 || sum < -128) e.ovf = 1'b1;
            end
        end
        return e;
    endfunction

    // One full operation. Returns at the negedge inside the expected done cycle.
    task automatic run_op(input string name, input logic [199:0] a, input logic [199:0] b,
                          input logic [2:0] sz, input int repulse, input bit pre_started,
                          input bit scramble);
        exp_t e;
        int   s, t1, dc;
        bit   exp_busy, exp_done, exp_mrst;
        s  = (sz == 3'd0 || sz > 3'd5) ? 5 : int'(sz);
        t1 = (s + 1) / 2;
        dc = 2 * t1 * t1 + 2;
        sb.push_back(ref_model(a, b, s));
        mat_a = a;
        mat_b = b;
        size  = sz;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= dc; k++) begin
            if (k > 1) @(negedge clk);
            start = (k == repulse);
            if (scramble && k == 2) begin
                mat_a = ~a;
                mat_b = ~b;
                size  = 3'd1;
            end
            exp_busy = (k < dc);
            exp_done = (k == dc);
            exp_mrst = !(k >= 2 && k <= dc - 1);
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, k, busy, exp_busy);
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_bad++;
                $display("FAIL %s done cycle %0d: got %b expected %b", name, k, done, exp_done);
            end
            n_cmp++;
            if (mult_rst !== exp_mrst) begin
                n_bad++;
                $display("FAIL %s mult_rst cycle %0d: got %b expected %b", name, k, mult_rst, exp_mrst);
            end
        end
        e = sb.pop_front();
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s no done within %0d cycles: got %b expected 1", name, dc, done);
        end else begin
            n_cmp++;
            if (result !== e.res) begin
                n_bad++;
                $display("FAIL %s result: got %h expected %h", name, result, e.res);
            end
            n_cmp++;
            if (ovf !== e.ovf) begin
                n_bad++;
                $display("FAIL %s ovf: got %b expected %b", name, ovf, e.ovf);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        size  = 3'd5;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, ovf, mult_rst} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset flags busy/done/ovf/mult_rst: got %b expected 0001", {busy, done, ovf, mult_rst});
        end
        n_cmp++;
        if (result !== '0 || mult_lin !== '0 || mult_col !== '0) begin
            n_bad++;
            $display("FAIL reset vectors: got result %h lin %h col %h expected all zero", result, mult_lin, mult_col);
        end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        run_op("ident_x_ramp_s5", mk(0, 0), mk(2, 0), 3'd5, -1, 1'b0, 1'b0);
    endtask

    task automatic test_small();
        run_op("ones_x_twos_s2", mk(1, 1), mk(1, 2), 3'd2, -1, 1'b0, 1'b0);
        run_op("neg_x_ones_s3", mk(1, -1), mk(1, 1), 3'd3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_sizes();
        run_op("size7_as_5", mk(2, 0), mk(0, 0), 3'd7, -1, 1'b0, 1'b0);
        run_op("size1", mk(1, 7), mk(1, -3), 3'd1, -1, 1'b0, 1'b0);
        run_op("size4_scrambled", mk(2, 0), mk(1, 1), 3'd4, -1, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        run_op("ovf_100x100", mk(1, 100), mk(1, 100), 3'd5, -1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ovf !== 1'b1) begin
                n_bad++;
                $display("FAIL ovf_hold idle cycle %0d: got %b expected 1", i, ovf);
            end
        end
        run_op("ovf_cleared_ident", mk(0, 0), mk(0, 0), 3'd5, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("repulse_c5", mk(0, 0), mk(2, 0), 3'd5, 5, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL start_in_done_ignored busy/done: got %b expected 00", {busy, done});
        end
        run_op("start_c21", mk(2, 0), mk(0, 0), 3'd5, -1, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        mat_a = mk(1, 100);
        mat_b = mk(1, 100);
        size  = 3'd5;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, ovf, mult_rst} !== 4'b0001) begin
            n_bad++;
            $display("FAIL midrst flags busy/done/ovf/mult_rst: got %b expected 0001", {busy, done, ovf, mult_rst});
        end
        n_cmp++;
        if (result !== '0 || mult_lin !== '0 || mult_col !== '0) begin
            n_bad++;
            $display("FAIL midrst vectors: got result %h lin %h col %h expected all zero", result, mult_lin, mult_col);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op("after_midrst", mk(0, 0), mk(2, 0), 3'd5, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_small();
        test_sizes();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
